// File: rtl/wb_master_ctrl.sv
// Single-outstanding Wishbone classic master with a valid/ready command port.
// Waits for ack/err to drop before re-strobing; every phase is bounded by TIMEOUT.
module wb_master_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [DW-1:0] cmd_dat_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_dat_o,
    output logic          rsp_err_o,
    output logic          rsp_tmo_o,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [AW-1:0] adr_o,
    output logic [DW-1:0] dat_o,
    input  logic [DW-1:0] dat_i,
    input  logic          ack_i,
    input  logic          err_i
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   res_dat;
    logic            res_err;
    logic            res_tmo;

    assign cmd_ready_o = (state == IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            res_dat     <= '0;
            res_err     <= 1'b0;
            res_tmo     <= 1'b0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
        end else begin
            // Response fields are only non-zero during the single pulse cycle
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        we_o  <= cmd_we_i;
                        adr_o <= cmd_adr_i;
                        dat_o <= cmd_dat_i;
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        cnt   <= '0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (err_i) begin
                        res_dat <= '0;
                        res_err <= 1'b1;
                        res_tmo <= 1'b0;
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        cnt     <= '0;
                        state   <= RELEASE;
                    end else if (ack_i) begin
                        res_dat <= we_o ? '0 : dat_i;
                        res_err <= 1'b0;
                        res_tmo <= 1'b0;
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        cnt     <= '0;
                        state   <= RELEASE;
                    end else if (cnt == LAST) begin
                        res_dat <= '0;
                        res_err <= 1'b1;
                        res_tmo <= 1'b1;
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        cnt     <= '0;
                        state   <= RELEASE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!ack_i && !err_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= res_dat;
                        rsp_err_o   <= res_err;
                        rsp_tmo_o   <= res_tmo;
                        state       <= IDLE;
                    end else if (cnt == LAST) begin
                        // Slave never released: report a timeout, drop data
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_tmo_o   <= 1'b1;
                        state       <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Directed bench for wb_master_ctrl with a small configurable Wishbone slave.
// Table vectors cover read/write/timeout/error/stuck-ack; sequences cover streaming and reset.
module tb_wb_master_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_tmo;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        err;

    always #5 clk = ~clk;

    wb_master_ctrl #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .rsp_valid_o(rsp_valid),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .rsp_tmo_o  (rsp_tmo),
        .cyc_o      (cyc),
        .stb_o      (stb),
        .we_o       (we),
        .adr_o      (adr),
        .dat_o      (wdat),
        .dat_i      (rdat),
        .ack_i      (ack),
        .err_i      (err)
    );

    // Slave: mode 0 ack, 1 silent, 2 ack+err, 3 ack stuck high; wt = wait states
    logic [1:0] mode;
    int         wt;
    int         scnt;
    logic       hold;
    logic       stuck;
    logic       hit;

    assign hit  = stb && (scnt >= wt);
    assign ack  = ((mode != 2'd1) && (hit || hold)) || stuck;
    assign err  = (mode == 2'd2) && (hit || hold);
    assign rdat = {16'hAAAA, adr[15:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt  <= 0;
            hold  <= 1'b0;
            stuck <= 1'b0;
        end else begin
            scnt  <= stb ? scnt + 1 : 0;
            hold  <= hit;
            stuck <= (mode == 2'd3) && (stuck || hit);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [1:0]  mode;
        int          wt;
        logic [31:0] edat;
        logic        eerr;
        logic        etmo;
        int          estb;
    } vec_t;

    vec_t vecs[10];

    task automatic run(input int idx, input vec_t v);
        int  nstb;
        bit  done;
        bit  stable;
        @(negedge clk);
        mode      = v.mode;
        wt        = v.wt;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_valid = 1'b1;
        chk($sformatf("v%0d_ready_idle", idx), 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk($sformatf("v%0d_issue_stb", idx), 64'(stb), 64'd1);
        nstb   = 0;
        done   = 1'b0;
        stable = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            if (stb) begin
                nstb++;
                if (we !== v.we || adr !== v.adr || wdat !== v.dat || cyc !== 1'b1)
                    stable = 1'b0;
            end
            if (rsp_valid) done = 1'b1;
            else @(negedge clk);
        end
        chk($sformatf("v%0d_rsp_seen", idx), 64'(done), 64'd1);
        chk($sformatf("v%0d_stb_cycles", idx), 64'(nstb), 64'(v.estb));
        chk($sformatf("v%0d_req_stable", idx), 64'(stable), 64'd1);
        if (done) begin
            chk($sformatf("v%0d_rsp_dat", idx), 64'(rsp_dat), 64'(v.edat));
            chk($sformatf("v%0d_rsp_err", idx), 64'(rsp_err), 64'(v.eerr));
            chk($sformatf("v%0d_rsp_tmo", idx), 64'(rsp_tmo), 64'(v.etmo));
            chk($sformatf("v%0d_cyc_at_rsp", idx), 64'(cyc), 64'd0);
            chk($sformatf("v%0d_ready_at_rsp", idx), 64'(cmd_ready), 64'd1);
            @(negedge clk);
            chk($sformatf("v%0d_pulse_len", idx), 64'(rsp_valid), 64'd0);
            chk($sformatf("v%0d_rsp_zero", idx), 64'({rsp_dat, rsp_err, rsp_tmo}), 64'd0);
        end
    endtask

    int acc;
    int pulses;
    int tp[3];
    int rise_bad;
    logic prev_stb;
    logic prev_ack;
    int nrsp;

    initial begin
        vecs[0] = '{1'b0, 32'h0,        32'h0,        2'd0, 0, 32'hAAAA0000, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b1, 32'h10,       32'h12345678, 2'd0, 0, 32'h0,        1'b0, 1'b0, 1};
        vecs[2] = '{1'b0, 32'h24,       32'h0,        2'd0, 3, 32'hAAAA0024, 1'b0, 1'b0, 4};
        vecs[3] = '{1'b0, 32'h30,       32'h0,        2'd1, 0, 32'h0,        1'b1, 1'b1, 16};
        vecs[4] = '{1'b1, 32'h34,       32'hDEADBEEF, 2'd1, 0, 32'h0,        1'b1, 1'b1, 16};
        vecs[5] = '{1'b0, 32'h8,        32'h0,        2'd2, 0, 32'h0,        1'b1, 1'b0, 1};
        vecs[6] = '{1'b0, 32'hC,        32'h0,        2'd2, 2, 32'h0,        1'b1, 1'b0, 3};
        vecs[7] = '{1'b0, 32'h4,        32'h0,        2'd3, 0, 32'h0,        1'b1, 1'b1, 1};
        vecs[8] = '{1'b1, 32'hFFFFFFFC, 32'hA5A5A5A5, 2'd0, 5, 32'h0,        1'b0, 1'b0, 6};
        vecs[9] = '{1'b0, 32'hFFFFFFFC, 32'h0,        2'd0, 15, 32'hAAAAFFFC, 1'b0, 1'b0, 16};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        mode      = 2'd0;
        wt        = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_cyc_stb_we", 64'({cyc, stb, we}), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_tmo, rsp_dat}), 64'd0);
        chk("rst_adr_dat", {adr, wdat}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run(i, vecs[i]);

        // Streaming: cmd_valid held for exactly three accepted reads
        mode      = 2'd0;
        wt        = 0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_valid = 1'b1;
        acc       = 0;
        pulses    = 0;
        rise_bad  = 0;
        prev_stb  = stb;
        prev_ack  = ack;
        for (int c = 0; c < 60; c++) begin
            if (cmd_valid && cmd_ready) begin
                if (acc == 3) cmd_valid = 1'b0;
                else acc++;
            end
            @(negedge clk);
            if (rsp_valid) begin
                if (pulses < 3) tp[pulses] = c;
                pulses++;
            end
            if (stb && !prev_stb && prev_ack) rise_bad++;
            prev_stb = stb;
            prev_ack = ack;
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", 64'(acc), 64'd3);
        chk("b2b_pulses", 64'(pulses), 64'd3);
        if (pulses >= 3) begin
            chk("b2b_gap01", 64'(tp[1] - tp[0]), 64'd4);
            chk("b2b_gap12", 64'(tp[2] - tp[1]), 64'd4);
        end
        chk("b2b_stb_rise_on_ack", 64'(rise_bad), 64'd0);

        // Reset in the middle of a REQ phase against a silent slave
        @(negedge clk);
        mode      = 2'd1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h40;
        cmd_dat   = 32'h55;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_req_stb", 64'(stb), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_cyc_stb", 64'({cyc, stb}), 64'd0);
        chk("mrst_ready", 64'(cmd_ready), 64'd1);
        chk("mrst_adr", 64'(adr), 64'd0);
        nrsp = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        chk("mrst_no_rsp", 64'(nrsp), 64'd0);
        chk("mrst_idle_stb", 64'(stb), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
